puf_ascon_session_ctrl: RTL and testbench

Session controller in front of the PUF-Ascon secure configuration manager. After reset it enrolls the PUF once with a fixed challenge, then arbitrates encrypt/decrypt requests from two requesters (0: on-chip BIST, 1: external test port) round-robin. It holds the selected start level until done or timeout, reports pass/fail per transaction and locks the manager out after repeated decrypt tag failures.

---
 rtl/puf_ascon_session_ctrl_pkg.sv | 27 ++
 rtl/puf_ascon_session_ctrl_if.sv | 45 ++++
 rtl/puf_ascon_session_ctrl_rr_arbiter2.sv | 39 +++
 rtl/puf_ascon_session_ctrl.sv | 153 +++++++++++++++
 tb/tb_puf_ascon_session_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/puf_ascon_session_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// puf_ascon_pkg
// Shared definitions for the PUF-Ascon session controller: controller state
// encoding, operation codes, the default enrollment challenge and the width
// of the consecutive-failure counter.
// No ports (package).
// ---------------------------------------------------------------------------
package puf_ascon_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_PUF_WAIT,
    ST_READY,
    ST_RUN,
    ST_RESP,
    ST_LOCKED
  } state_t;

  localparam logic OP_ENC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  localparam logic [4:0] DEFAULT_CHALLENGE = 5'h0A;

  localparam int FAIL_CNT_W = 3;
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = '1;

endpackage

// File: rtl/puf_ascon_session_ctrl_if.sv
// ---------------------------------------------------------------------------
// puf_ascon_session_ctrl_if
// Bundles every non-clock signal of the session controller.
//   Requester side : req, req_op (in) / gnt, rsp_valid, rsp_ok, rsp_id (out)
//   Status         : busy, locked, err_timeout, fail_cnt (out)
//   PUF side       : puf_generate, puf_challenge (out) / puf_ready (in)
//   Manager side   : encrypt_start, decrypt_start (out) /
//                    encrypt_done, decrypt_done, decryption_valid (in)
// Modports: slave = controller view, master = environment view.
// ---------------------------------------------------------------------------
interface puf_ascon_session_ctrl_if;
  import puf_ascon_pkg::*;

  logic [1:0]            req;
  logic [1:0]            req_op;
  logic [1:0]            gnt;
  logic                  rsp_valid;
  logic                  rsp_ok;
  logic                  rsp_id;
  logic                  busy;
  logic                  locked;
  logic                  err_timeout;
  logic [FAIL_CNT_W-1:0] fail_cnt;
  logic                  puf_generate;
  logic [4:0]            puf_challenge;
  logic                  puf_ready;
  logic                  encrypt_start;
  logic                  decrypt_start;
  logic                  encrypt_done;
  logic                  decrypt_done;
  logic                  decryption_valid;

  modport slave (
    input  req, req_op, puf_ready, encrypt_done, decrypt_done, decryption_valid,
    output gnt, rsp_valid, rsp_ok, rsp_id, busy, locked, err_timeout, fail_cnt,
           puf_generate, puf_challenge, encrypt_start, decrypt_start
  );

  modport master (
    output req, req_op, puf_ready, encrypt_done, decrypt_done, decryption_valid,
    input  gnt, rsp_valid, rsp_ok, rsp_id, busy, locked, err_timeout, fail_cnt,
           puf_generate, puf_challenge, encrypt_start, decrypt_start
  );

endinterface

// File: rtl/puf_ascon_session_ctrl_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter. gnt is combinational one-hot; the
// last-served pointer advances only when en is high and a request exists.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : request vector
//   en         : grant enable (grant actually taken this cycle)
//   gnt        : one-hot grant
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // Pointer resets to 1 so requester 0 wins the first contested round.
  logic last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (en && (req != 2'b00)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/puf_ascon_session_ctrl.sv
// ---------------------------------------------------------------------------
// puf_ascon_session_ctrl
// Session controller in front of the PUF-Ascon configuration manager.
// Enrolls the PUF once after reset, then serves encrypt/decrypt requests
// from two requesters round-robin, reports pass/fail per transaction and
// locks out after MAX_FAIL consecutive failed decrypts or timeouts.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave modport carrying all requester, PUF and manager signals
// ---------------------------------------------------------------------------
module puf_ascon_session_ctrl
  import puf_ascon_pkg::*;
#(
  parameter int         MAX_FAIL  = 3,
  parameter int         TIMEOUT   = 1023,
  parameter logic [4:0] CHALLENGE = DEFAULT_CHALLENGE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  puf_ascon_session_ctrl_if.slave  bus
);

  localparam logic [15:0]           TIMEOUT_VAL = 16'(TIMEOUT);
  localparam logic [FAIL_CNT_W-1:0] FAIL_LIMIT  = FAIL_CNT_W'(MAX_FAIL);

  state_t                state;
  logic [15:0]           wait_cnt;
  logic                  cur_op;
  logic                  cur_id;
  logic [1:0]            arb_gnt;
  logic                  grant_op;
  logic                  timeout_hit;
  logic                  run_done;
  logic                  run_ok;
  logic [FAIL_CNT_W-1:0] fail_next;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.req),
    .en    (state == ST_READY),
    .gnt   (arb_gnt)
  );

  // Only the done matching the latched op counts; a timeout is a failure.
  // fail_next is the counter value committed when RUN ends.
  always_comb begin
    grant_op    = arb_gnt[1] ? bus.req_op[1] : bus.req_op[0];
    timeout_hit = (wait_cnt == TIMEOUT_VAL);
    run_done    = (cur_op == OP_DEC) ? bus.decrypt_done : bus.encrypt_done;
    run_ok      = run_done && ((cur_op == OP_ENC) || bus.decryption_valid);
    fail_next   = bus.fail_cnt;
    if (run_ok && (cur_op == OP_DEC)) begin
      fail_next = '0;
    end else if (!run_ok && (bus.fail_cnt != FAIL_CNT_MAX)) begin
      fail_next = bus.fail_cnt + FAIL_CNT_W'(1);
    end
  end

  // Wait counter restarts on every state change so RUN entry at cycle S
  // hits TIMEOUT at S+TIMEOUT; done in that same cycle takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_BOOT;
      wait_cnt          <= '0;
      cur_op            <= OP_ENC;
      cur_id            <= 1'b0;
      bus.gnt           <= 2'b00;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_ok        <= 1'b0;
      bus.rsp_id        <= 1'b0;
      bus.busy          <= 1'b0;
      bus.locked        <= 1'b0;
      bus.err_timeout   <= 1'b0;
      bus.fail_cnt      <= '0;
      bus.puf_generate  <= 1'b0;
      bus.puf_challenge <= CHALLENGE;
      bus.encrypt_start <= 1'b0;
      bus.decrypt_start <= 1'b0;
    end else begin
      bus.gnt       <= 2'b00;
      bus.rsp_valid <= 1'b0;
      wait_cnt      <= wait_cnt + 16'd1;
      case (state)
        ST_BOOT: begin
          state             <= ST_PUF_WAIT;
          wait_cnt          <= '0;
          bus.busy          <= 1'b1;
          bus.puf_generate  <= 1'b1;
          bus.puf_challenge <= CHALLENGE;
        end
        ST_PUF_WAIT: begin
          if (bus.puf_ready) begin
            state            <= ST_READY;
            wait_cnt         <= '0;
            bus.busy         <= 1'b0;
            bus.puf_generate <= 1'b0;
          end else if (timeout_hit) begin
            state            <= ST_LOCKED;
            wait_cnt         <= '0;
            bus.puf_generate <= 1'b0;
            bus.err_timeout  <= 1'b1;
            bus.locked       <= 1'b1;
          end
        end
        ST_READY: begin
          if (bus.req != 2'b00) begin
            state             <= ST_RUN;
            wait_cnt          <= '0;
            bus.busy          <= 1'b1;
            bus.gnt           <= arb_gnt;
            cur_id            <= arb_gnt[1];
            cur_op            <= grant_op;
            bus.encrypt_start <= (grant_op == OP_ENC);
            bus.decrypt_start <= (grant_op == OP_DEC);
          end
        end
        ST_RUN: begin
          if (run_done || timeout_hit) begin
            state             <= ST_RESP;
            wait_cnt          <= '0;
            bus.encrypt_start <= 1'b0;
            bus.decrypt_start <= 1'b0;
            bus.rsp_valid     <= 1'b1;
            bus.rsp_ok        <= run_ok;
            bus.rsp_id        <= cur_id;
            bus.fail_cnt      <= fail_next;
            if (!run_done) begin
              bus.err_timeout <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          wait_cnt <= '0;
          if (bus.fail_cnt >= FAIL_LIMIT) begin
            state      <= ST_LOCKED;
            bus.locked <= 1'b1;
          end else begin
            state    <= ST_READY;
            bus.busy <= 1'b0;
          end
        end
        ST_LOCKED: begin
          wait_cnt <= '0;
        end
        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_ascon_session_ctrl.sv
// ---------------------------------------------------------------------------
// tb_puf_ascon_session_ctrl
// Self-checking bench for puf_ascon_session_ctrl. A transaction-level model
// predicts grant winner, response latency, ok, fail count and lockout from
// the session rules; stimulus is mixed directed and $urandom.
// ---------------------------------------------------------------------------
module tb_puf_ascon_session_ctrl;
  import puf_ascon_pkg::*;

  localparam int         MAX_FAIL = 3;
  localparam int         TIMEOUT  = 24;
  localparam logic [4:0] CHAL     = 5'h0A;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int m_last;
  int m_fail;
  bit m_err;
  bit m_locked;

  puf_ascon_session_ctrl_if bus();

  puf_ascon_session_ctrl #(
    .MAX_FAIL  (MAX_FAIL),
    .TIMEOUT   (TIMEOUT),
    .CHALLENGE (CHAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.req              = 2'b00;
    bus.req_op           = 2'b00;
    bus.puf_ready        = 1'b0;
    bus.encrypt_done     = 1'b0;
    bus.decrypt_done     = 1'b0;
    bus.decryption_valid = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_gnt"},   32'(bus.gnt), 32'd0);
    checkOutput({tag, "_rspv"},  32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, "_rspok"}, 32'(bus.rsp_ok), 32'd0);
    checkOutput({tag, "_rspid"}, 32'(bus.rsp_id), 32'd0);
    checkOutput({tag, "_busy"},  32'(bus.busy), 32'd0);
    checkOutput({tag, "_lock"},  32'(bus.locked), 32'd0);
    checkOutput({tag, "_err"},   32'(bus.err_timeout), 32'd0);
    checkOutput({tag, "_fail"},  32'(bus.fail_cnt), 32'd0);
    checkOutput({tag, "_pgen"},  32'(bus.puf_generate), 32'd0);
    checkOutput({tag, "_chal"},  32'(bus.puf_challenge), 32'(CHAL));
    checkOutput({tag, "_encs"},  32'(bus.encrypt_start), 32'd0);
    checkOutput({tag, "_decs"},  32'(bus.decrypt_start), 32'd0);
  endtask

  // Reset, then enroll; ready_cycle = 0 means puf_ready never comes.
  // Requests are held during enrollment and must not be granted.
  task automatic enroll(input int ready_cycle);
    int last_c;
    clearInputs();
    rst_n = 1'b0;
    step();
    step();
    checkIdle("reset");
    m_last   = 1;
    m_fail   = 0;
    m_err    = 1'b0;
    m_locked = 1'b0;
    rst_n    = 1'b1;
    bus.req    = 2'b11;
    bus.req_op = 2'($urandom);
    checkOutput("boot_pgen", 32'(bus.puf_generate), 32'd0);
    step();
    last_c = (ready_cycle != 0) ? ready_cycle : TIMEOUT + 1;
    for (int c = 1; c <= last_c; c++) begin
      checkOutput("enr_pgen", 32'(bus.puf_generate), 32'd1);
      checkOutput("enr_chal", 32'(bus.puf_challenge), 32'(CHAL));
      checkOutput("enr_busy", 32'(bus.busy), 32'd1);
      checkOutput("enr_gnt",  32'(bus.gnt), 32'd0);
      if (c == ready_cycle) begin
        bus.puf_ready = 1'b1;
        bus.req       = 2'b00;
      end
      step();
    end
    bus.puf_ready = 1'b0;
    bus.req       = 2'b00;
    checkOutput("enr_end_pgen", 32'(bus.puf_generate), 32'd0);
    if (ready_cycle != 0) begin
      checkOutput("enr_ready_busy", 32'(bus.busy), 32'd0);
      checkOutput("enr_ready_lock", 32'(bus.locked), 32'd0);
      step();
      checkOutput("enr_ready_gnt", 32'(bus.gnt), 32'd0);
    end else begin
      m_locked = 1'b1;
      m_err    = 1'b1;
      checkOutput("enr_to_lock", 32'(bus.locked), 32'd1);
      checkOutput("enr_to_err",  32'(bus.err_timeout), 32'd1);
      checkOutput("enr_to_busy", 32'(bus.busy), 32'd1);
    end
  endtask

  // One transaction from a READY cycle. delay = cycles after RUN entry at
  // which the matching done is driven; beyond TIMEOUT it is never driven.
  task automatic applyStimulus(input logic [1:0] rq, input logic [1:0] ops,
                               input int delay, input logic valid);
    int   id;
    int   lat;
    logic op;
    bit   hit;
    bit   ok;
    if (rq == 2'b11) id = (m_last == 1) ? 0 : 1;
    else             id = rq[1] ? 1 : 0;
    op = ops[id];
    bus.req    = rq;
    bus.req_op = ops;
    step();
    checkOutput("gnt", 32'(bus.gnt), (id == 1) ? 32'd2 : 32'd1);
    checkOutput("run_busy", 32'(bus.busy), 32'd1);
    m_last     = id;
    bus.req    = 2'b00;
    bus.req_op = 2'($urandom);
    hit = (delay <= TIMEOUT);
    lat = hit ? delay : TIMEOUT;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) checkOutput("gnt_pulse", 32'(bus.gnt), 32'd0);
      checkOutput("enc_start", 32'(bus.encrypt_start), 32'(op == 1'b0));
      checkOutput("dec_start", 32'(bus.decrypt_start), 32'(op == 1'b1));
      checkOutput("rsp_early", 32'(bus.rsp_valid), 32'd0);
      bus.decryption_valid = 1'($urandom);
      if (op == 1'b0) begin
        bus.encrypt_done = (k == delay);
        bus.decrypt_done = 1'($urandom);
      end else begin
        bus.decrypt_done = (k == delay);
        bus.encrypt_done = 1'($urandom);
      end
      if (k == delay) bus.decryption_valid = valid;
      step();
    end
    bus.encrypt_done     = 1'b0;
    bus.decrypt_done     = 1'b0;
    bus.decryption_valid = 1'b0;
    ok = hit && ((op == 1'b0) || valid);
    if (!hit) m_err = 1'b1;
    if (op == 1'b1 && ok)     m_fail = 0;
    else if (!ok && m_fail < 7) m_fail++;
    checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("rsp_ok",    32'(bus.rsp_ok), 32'(ok));
    checkOutput("rsp_id",    32'(bus.rsp_id), 32'(id));
    checkOutput("fail_cnt",  32'(bus.fail_cnt), 32'(m_fail));
    checkOutput("err_to",    32'(bus.err_timeout), 32'(m_err));
    checkOutput("rsp_encs",  32'(bus.encrypt_start), 32'd0);
    checkOutput("rsp_decs",  32'(bus.decrypt_start), 32'd0);
    step();
    checkOutput("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    if (m_fail >= MAX_FAIL) m_locked = 1'b1;
    checkOutput("locked", 32'(bus.locked), 32'(m_locked));
    checkOutput("busy_after", 32'(bus.busy), 32'(m_locked));
  endtask

  task automatic checkLocked();
    for (int k = 0; k < 8; k++) begin
      bus.req    = 2'($urandom_range(1, 3));
      bus.req_op = 2'($urandom);
      step();
      checkOutput("lk_gnt",  32'(bus.gnt), 32'd0);
      checkOutput("lk_encs", 32'(bus.encrypt_start), 32'd0);
      checkOutput("lk_decs", 32'(bus.decrypt_start), 32'd0);
      checkOutput("lk_pgen", 32'(bus.puf_generate), 32'd0);
      checkOutput("lk_lock", 32'(bus.locked), 32'd1);
    end
    bus.req = 2'b00;
  endtask

  initial begin
    int d;
    clearInputs();

    // Enrollment with puf_ready at cycle 4
    enroll(4);

    // Encrypt, start held 20 cycles
    applyStimulus(2'b01, 2'b00, 19, 1'b0);

    // Both requesting twice: round-robin alternates
    applyStimulus(2'b11, 2'b00, 3, 1'b0);
    applyStimulus(2'b11, 2'b00, 2, 1'b0);

    // Three failed decrypts lock the manager out
    applyStimulus(2'b01, 2'b01, 5, 1'b0);
    applyStimulus(2'b10, 2'b10, 0, 1'b0);
    applyStimulus(2'b01, 2'b11, 7, 1'b0);
    checkLocked();

    // Decrypt timeout, then done coinciding with timeout
    enroll(int'($urandom_range(1, 6)));
    applyStimulus(2'b10, 2'b10, TIMEOUT + 5, 1'b0);
    applyStimulus(2'b01, 2'b01, TIMEOUT, 1'b1);

    // Reset asserted mid-RUN
    bus.req    = 2'b01;
    bus.req_op = 2'b01;
    step();
    bus.req = 2'b00;
    step();
    step();
    checkOutput("midrun_decs", 32'(bus.decrypt_start), 32'd1);
    rst_n = 1'b0;
    step();
    checkIdle("midrun_rst");

    // PUF never answers: enrollment timeout locks out
    enroll(0);
    checkLocked();

    // Randomized traffic
    enroll(int'($urandom_range(1, 8)));
    for (int n = 0; n < 60; n++) begin
      if (m_locked) begin
        checkLocked();
        enroll(int'($urandom_range(1, 8)));
      end
      if ($urandom_range(0, 4) == 0) d = TIMEOUT + int'($urandom_range(1, 4));
      else                           d = int'($urandom_range(0, TIMEOUT));
      applyStimulus(2'($urandom_range(1, 3)), 2'($urandom), d,
                    ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
